// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the single-cycle-style CPU. Owns the program counter, fetches
// instruction words over a ready handshake and holds the fetched word stable
// in EXEC while control_unit and the datapath work on it. On leaving EXEC the
// PC is loaded from the Jump / Branch+Zero / pc+4 selection.
//
// Optional feature macro: IFETCH_INSTR_COUNT_EN
//   defined   -> instrCount port and retired-instruction counter exist
//   undefined -> no counter, no port; everything else identical
//
// Parameters:
//   RESET_PC         PC loaded on reset (word-aligned)
//
// Ports:
//   clk              clock, rising edge
//   reset            synchronous, active-high
//   imemReq          fetch request to instruction memory (registered)
//   imemAddr         word-aligned byte address of the request (= pc)
//   imemReady        memory presents valid imemData this cycle
//   imemData         instruction word from memory
//   instructionWord  held instruction for control_unit
//   instrValid       instructionWord is valid for execution
//   pcPlus4          pc of the held instruction + 4
//   stall            downstream hold while in EXEC
//   Branch/Jump/Zero decode + ALU flag for the held instruction
//   instrCount       retired-instruction counter (feature macro only)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instructionWord,
    output logic        instrValid,
    output logic [31:0] pcPlus4,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero
`ifdef IFETCH_INSTR_COUNT_EN
    ,
    output logic [31:0] instrCount
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // Low bits forced to zero so imemAddr stays word-aligned whatever is passed.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcPlus4_q, pcPlus4_d;
    logic [31:0] word_q, word_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc;
    logic [31:0] branch_off;

    // Next-PC selection. Jump is tested first so X on Branch/Zero under a jump
    // never reaches pc.
    always_comb begin
        branch_off = {{14{word_q[15]}}, word_q[15:0], 2'b00};
        next_pc    = pcPlus4_q;
        if (Jump) begin
            next_pc = {pcPlus4_q[31:28], word_q[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pcPlus4_q + branch_off;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pcPlus4_d = pcPlus4_q;
        word_d    = word_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imemReady) begin
                    state_d = EXEC;
                    word_d  = imemData;
                end
            end
            EXEC: begin
                if (!stall) begin
                    state_d   = FETCH;
                    pc_d      = next_pc;
                    pcPlus4_d = next_pc + 32'd4;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs registered from the next state so they line up with it.
        req_d   = (state_d == FETCH);
        valid_d = (state_d == EXEC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC_ALIGNED;
            pcPlus4_q <= RESET_PC_ALIGNED + 32'd4;
            word_q    <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pcPlus4_q <= pcPlus4_d;
            word_q    <= word_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
        end
    end

    assign imemReq         = req_q;
    assign imemAddr        = pc_q;
    assign instructionWord = word_q;
    assign instrValid      = valid_q;
    assign pcPlus4         = pcPlus4_q;

`ifdef IFETCH_INSTR_COUNT_EN
    logic [31:0] count_q, count_d;

    // One retirement per EXEC->FETCH transition; wraps naturally at 2^32.
    always_comb begin
        count_d = count_q;
        if (state_q == EXEC && !stall) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign instrCount = count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    typedef struct {
        string       name;
        logic        rst;
        logic        rdy;
        logic [31:0] data;
        logic        stall;
        logic        br;
        logic        jmp;
        logic        z;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_word;
        logic [31:0] e_pp4;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReady;
    logic [31:0] imemData;
    logic        stall, Branch, Jump, Zero;

    logic        a_req, b_req;
    logic [31:0] a_addr, b_addr;
    logic [31:0] a_word, b_word;
    logic        a_valid, b_valid;
    logic [31:0] a_pp4, b_pp4;
`ifdef IFETCH_INSTR_COUNT_EN
    logic [31:0] a_cnt, b_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    vec_t        vq[$];

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0040)) u_a (
        .clk(clk), .reset(reset), .imemReq(a_req), .imemAddr(a_addr),
        .imemReady(imemReady), .imemData(imemData), .instructionWord(a_word),
        .instrValid(a_valid), .pcPlus4(a_pp4), .stall(stall), .Branch(Branch),
        .Jump(Jump), .Zero(Zero)
`ifdef IFETCH_INSTR_COUNT_EN
        , .instrCount(a_cnt)
`endif
    );

    instruction_fetch #(.RESET_PC(32'h8000_0010)) u_b (
        .clk(clk), .reset(reset), .imemReq(b_req), .imemAddr(b_addr),
        .imemReady(imemReady), .imemData(imemData), .instructionWord(b_word),
        .instrValid(b_valid), .pcPlus4(b_pp4), .stall(stall), .Branch(Branch),
        .Jump(Jump), .Zero(Zero)
`ifdef IFETCH_INSTR_COUNT_EN
        , .instrCount(b_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic rst, input logic rdy,
                                input logic [31:0] data, input logic st, input logic br,
                                input logic jmp, input logic z, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_word, input logic [31:0] e_pp4);
        vec_t v;
        v.name = name; v.rst = rst; v.rdy = rdy; v.data = data; v.stall = st;
        v.br = br; v.jmp = jmp; v.z = z; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_word = e_word; v.e_pp4 = e_pp4;
        vq.push_back(v);
    endfunction

    // Drive one cycle of inputs, then check instance A just after the edge.
    task automatic step(input vec_t v);
        reset = v.rst; imemReady = v.rdy; imemData = v.data; stall = v.stall;
        Branch = v.br; Jump = v.jmp; Zero = v.z;
        @(posedge clk);
        #1;
        n_vec++;
        chk({v.name, ".req"},   {31'd0, a_req},   {31'd0, v.e_req});
        chk({v.name, ".addr"},  a_addr,           v.e_addr);
        chk({v.name, ".valid"}, {31'd0, a_valid}, {31'd0, v.e_valid});
        chk({v.name, ".word"},  a_word,           v.e_word);
        chk({v.name, ".pp4"},   a_pp4,            v.e_pp4);
    endtask

    localparam logic [31:0] D0 = 32'h0123_4567;
    localparam logic [31:0] D1 = 32'h89AB_CDEF;
    localparam logic [31:0] D2 = 32'h1000_FFEC; // offset -0x14 words
    localparam logic [31:0] D3 = 32'h0000_0020;
    localparam logic [31:0] D4 = 32'h0800_0040; // jump index 0x40
    localparam logic [31:0] D5 = 32'h1000_FFFE; // offset -2 words
    localparam logic [31:0] D7 = 32'h1000_FFBD; // offset -0x43 words
    localparam logic [31:0] D8 = 32'hDEAD_BEEF;

    initial begin
        vec_t h;
        reset = 1'b1; imemReady = 1'b0; imemData = '0;
        stall = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;

        // Hand sequence: jump with Branch/Zero = X, both reset PCs.
        add("j_rst",  1, 0, 32'h0, 0, 0, 0, 0,       0, 32'h40, 0, 32'h0, 32'h44);
        add("j_idle", 0, 0, 32'h0, 0, 0, 0, 0,       1, 32'h40, 0, 32'h0, 32'h44);
        add("j_cap",  0, 1, D4,    0, 0, 0, 0,       0, 32'h40, 1, D4,    32'h44);
        add("j_jump", 0, 0, 32'h0, 0, 1'bx, 1, 1'bx, 1, 32'h100, 0, D4,   32'h104);
        for (int i = 0; i < 4; i++) begin
            step(vq[i]);
            case (i)
                0: chk("b_reset_addr", b_addr, 32'h8000_0010);
                0: ;
                2: chk("b_cap_word", b_word, D4);
                3: begin
                    chk("b_jump_addr", b_addr, 32'h8000_0100);
                    chk("b_jump_pp4", b_pp4, 32'h8000_0104);
                   end
                default: chk("b_req", {31'd0, b_req}, 32'd1);
            endcase
        end
        vq.delete();

        // Main table (instance A, RESET_PC = 0x40).
        add("reset",   1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h40, 0, 32'h0, 32'h44);
        add("idle",    0, 1, D8,    0, 0, 0, 0, 1, 32'h40, 0, 32'h0, 32'h44);
        add("cap0",    0, 1, D0,    0, 0, 0, 0, 0, 32'h40, 1, D0,    32'h44);
        add("seq44",   0, 1, D8,    0, 0, 0, 0, 1, 32'h44, 0, D0,    32'h48);
        add("cap1",    0, 1, D1,    0, 0, 0, 0, 0, 32'h44, 1, D1,    32'h48);
        add("seq48",   0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h48, 0, D1,    32'h4C);
        for (int i = 0; i < 3; i++)
            add("wait",  0, 0, D8,  0, 0, 0, 0, 1, 32'h48, 0, D1,    32'h4C);
        add("cap2",    0, 1, D2,    0, 0, 0, 0, 0, 32'h48, 1, D2,    32'h4C);
        for (int i = 0; i < 5; i++)
            add("stall", 0, 1, D8,  1, 1, 0, 1, 0, 32'h48, 1, D2,    32'h4C);
        add("negbr",   0, 0, 32'h0, 0, 1, 0, 1, 1, 32'hFFFF_FFFC, 0, D2, 32'h0);
        add("fignore", 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'hFFFF_FFFC, 0, D2, 32'h0);
        add("cap3",    0, 1, D3,    0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, D3, 32'h0);
        add("wrap",    0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h0,   0, D3,    32'h4);
        add("cap4",    0, 1, D4,    0, 0, 0, 0, 0, 32'h0,   1, D4,    32'h4);
        add("jump",    0, 0, 32'h0, 0, 1'bx, 1, 1'bx, 1, 32'h100, 0, D4, 32'h104);
        add("cap5",    0, 1, D5,    0, 0, 0, 0, 0, 32'h100, 1, D5,    32'h104);
        add("brtaken", 0, 0, 32'h0, 0, 1, 0, 1, 1, 32'hFC,  0, D5,    32'h100);
        add("cap6",    0, 1, D4,    0, 0, 0, 0, 0, 32'hFC,  1, D4,    32'h100);
        add("jump2",   0, 0, 32'h0, 0, 0, 1, 0, 1, 32'h100, 0, D4,    32'h104);
        add("cap7",    0, 1, D5,    0, 0, 0, 0, 0, 32'h100, 1, D5,    32'h104);
        add("brnot",   0, 0, 32'h0, 0, 1, 0, 0, 1, 32'h104, 0, D5,    32'h108);
        add("cap8",    0, 1, D7,    0, 0, 0, 0, 0, 32'h104, 1, D7,    32'h108);
        add("brwrap",  0, 0, 32'h0, 0, 1, 0, 1, 1, 32'hFFFF_FFFC, 0, D7, 32'h0);
        add("rstfet",  1, 1, D8,    0, 0, 0, 0, 0, 32'h40,  0, 32'h0, 32'h44);
        add("restart", 0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h40,  0, 32'h0, 32'h44);
        add("cap9",    0, 1, D4,    0, 0, 0, 0, 0, 32'h40,  1, D4,    32'h44);
        add("rstexe",  1, 0, 32'h0, 0, 1, 1, 1, 0, 32'h40,  0, 32'h0, 32'h44);
        add("restart2",0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h40,  0, 32'h0, 32'h44);
        foreach (vq[i]) step(vq[i]);
        vq.delete();

        // Hand sequence: retirement counter across a long stall.
        h = '{name: "cnt_rst", rst: 1, rdy: 0, data: 32'h0, stall: 0, br: 0, jmp: 0, z: 0,
              e_req: 0, e_addr: 32'h40, e_valid: 0, e_word: 32'h0, e_pp4: 32'h44};
        step(h);
`ifdef IFETCH_INSTR_COUNT_EN
        chk("cnt_reset", a_cnt, 32'd0);
`endif
        h.name = "cnt_idle"; h.rst = 0; h.e_req = 1;
        step(h);
        h.name = "cnt_cap"; h.rdy = 1; h.data = D1; h.e_req = 0; h.e_valid = 1; h.e_word = D1;
        step(h);
        h.name = "cnt_stall"; h.rdy = 0; h.stall = 1;
        for (int i = 0; i < 5; i++) step(h);
`ifdef IFETCH_INSTR_COUNT_EN
        chk("cnt_held", a_cnt, 32'd0);
`endif
        h.name = "cnt_rel"; h.stall = 0; h.e_req = 1; h.e_addr = 32'h44; h.e_valid = 0;
        h.e_pp4 = 32'h48;
        step(h);
`ifdef IFETCH_INSTR_COUNT_EN
        chk("cnt_once", a_cnt, 32'd1);
`endif
        h.name = "cnt_idle2";
        step(h);
`ifdef IFETCH_INSTR_COUNT_EN
        chk("cnt_fetch", a_cnt, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
